// File: rtl/cpu_register_bank.sv
// NREG x W register bank with one arithmetic write port, two combinational read ports and registered carry/zero flags.
// Optional macro CPU_REGBANK_BYPASS_EN forwards the result being written to a matching read port in the same cycle.
module cpu_register_bank #(
    parameter int W    = 4,
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic          clk_cpu,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] wr_sel,
    input  logic [1:0]    wr_op,
    input  logic [W-1:0]  dat_in,
    input  logic [AW-1:0] rd_sel_a,
    input  logic [AW-1:0] rd_sel_b,
    output logic [W-1:0]  dat_out_a,
    output logic [W-1:0]  dat_out_b,
    output logic          carry,
    output logic          zero
);

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_INC   = 2'b01,
        OP_DEC   = 2'b10,
        OP_CLEAR = 2'b11
    } wr_op_e;

    localparam logic [W-1:0] ZERO_W   = {W{1'b0}};
    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
    localparam logic [W-1:0] ONE_W    = W'(1);

    logic [W-1:0] regs_q [NREG];
    logic [W-1:0] regs_d [NREG];
    logic         carry_q;
    logic         carry_d;
    logic         zero_q;
    logic         zero_d;

    logic         wr_hit_s;
    logic         wr_ok_s;
    logic [W-1:0] wr_old_s;
    logic [W-1:0] wr_res_s;
    logic         wr_cry_s;
    logic [W-1:0] rd_a_s;
    logic [W-1:0] rd_b_s;

    // Locate the destination register; indices at or above NREG never hit.
    always_comb begin
        wr_hit_s = 1'b0;
        wr_old_s = ZERO_W;
        for (int i = 0; i < NREG; i++) begin
            wr_hit_s = wr_hit_s | (wr_sel == AW'(i));
            wr_old_s = (wr_sel == AW'(i)) ? regs_q[i] : wr_old_s;
        end
    end

    assign wr_ok_s = we & ~reset & wr_hit_s;

    // Result and carry/borrow of the requested in-place operation.
    always_comb begin
        wr_res_s = ZERO_W;
        wr_cry_s = 1'b0;
        case (wr_op_e'(wr_op))
            OP_LOAD: begin
                wr_res_s = dat_in;
                wr_cry_s = 1'b0;
            end
            OP_INC: begin
                wr_res_s = wr_old_s + ONE_W;
                wr_cry_s = (wr_old_s == ALL_ONES);
            end
            OP_DEC: begin
                wr_res_s = wr_old_s - ONE_W;
                wr_cry_s = (wr_old_s == ZERO_W);
            end
            OP_CLEAR: begin
                wr_res_s = ZERO_W;
                wr_cry_s = 1'b0;
            end
            default: begin
                wr_res_s = ZERO_W;
                wr_cry_s = 1'b0;
            end
        endcase
    end

    // Next-state: only an accepted write touches a register or the flags.
    always_comb begin
        carry_d = carry_q;
        zero_d  = zero_q;
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = (wr_ok_s && (wr_sel == AW'(i))) ? wr_res_s : regs_q[i];
        end
        if (wr_ok_s) begin
            carry_d = wr_cry_s;
            zero_d  = (wr_res_s == ZERO_W);
        end else begin
            carry_d = carry_q;
            zero_d  = zero_q;
        end
    end

    // State registers with synchronous reset taking priority over writes.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= ZERO_W;
            end
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    // Read muxes; unmatched (out-of-range) indices fall through to zero.
    always_comb begin
        rd_a_s = ZERO_W;
        rd_b_s = ZERO_W;
        for (int i = 0; i < NREG; i++) begin
            rd_a_s = (rd_sel_a == AW'(i)) ? regs_q[i] : rd_a_s;
            rd_b_s = (rd_sel_b == AW'(i)) ? regs_q[i] : rd_b_s;
        end
`ifdef CPU_REGBANK_BYPASS_EN
        rd_a_s = (wr_ok_s && (rd_sel_a == wr_sel)) ? wr_res_s : rd_a_s;
        rd_b_s = (wr_ok_s && (rd_sel_b == wr_sel)) ? wr_res_s : rd_b_s;
`endif
    end

    assign dat_out_a = rd_a_s;
    assign dat_out_b = rd_b_s;
    assign carry     = carry_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cpu_register_bank.sv
// Bench for cpu_register_bank: a 4-register and a 3-register instance share stimulus and are checked against an integer model.
`timescale 1ns/1ps
module tb_cpu_register_bank;

    logic       clk_cpu = 1'b0;
    always #5 clk_cpu = ~clk_cpu;

    logic       reset    = 1'b1;
    logic       we       = 1'b0;
    logic [1:0] wr_sel   = 2'd0;
    logic [1:0] wr_op    = 2'd0;
    logic [3:0] dat_in   = 4'd0;
    logic [1:0] rd_sel_a = 2'd0;
    logic [1:0] rd_sel_b = 2'd0;

    logic [3:0] a4, b4, a3, b3;
    logic       c4, z4, c3, z3;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    int nreg [2] = '{4, 3};
    int mreg [2][4];
    int mcarry [2];
    int mzero [2];

    cpu_register_bank #(.W(4), .NREG(4), .AW(2)) u4 (
        .clk_cpu(clk_cpu), .reset(reset), .we(we), .wr_sel(wr_sel), .wr_op(wr_op),
        .dat_in(dat_in), .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
        .dat_out_a(a4), .dat_out_b(b4), .carry(c4), .zero(z4)
    );

    cpu_register_bank #(.W(4), .NREG(3), .AW(2)) u3 (
        .clk_cpu(clk_cpu), .reset(reset), .we(we), .wr_sel(wr_sel), .wr_op(wr_op),
        .dat_in(dat_in), .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
        .dat_out_a(a3), .dat_out_b(b3), .carry(c3), .zero(z3)
    );

    function automatic bit write_ok(input int k);
        return (we == 1'b1) && (reset == 1'b0) && (int'(wr_sel) < nreg[k]);
    endfunction

    // Result of the current write on model instance k, plus its carry.
    function automatic int result(input int k, output int c);
        int old;
        old = mreg[k][int'(wr_sel)];
        c = 0;
        case (int'(wr_op))
            0: return int'(dat_in);
            1: begin c = (old == 15) ? 1 : 0; return (old + 1) % 16; end
            2: begin c = (old == 0) ? 1 : 0; return (old + 15) % 16; end
            default: return 0;
        endcase
    endfunction

    function automatic int exp_rd(input int k, input int sel);
        int c;
        if (sel >= nreg[k]) return 0;
`ifdef CPU_REGBANK_BYPASS_EN
        if (write_ok(k) && sel == int'(wr_sel)) return result(k, c);
`endif
        return mreg[k][sel];
    endfunction

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Every cycle, mid-period: all outputs of both instances against the model.
    always @(negedge clk_cpu) begin
        if (chk_en) begin
            check("u4.dat_out_a", a4, 4'(exp_rd(0, int'(rd_sel_a))));
            check("u4.dat_out_b", b4, 4'(exp_rd(0, int'(rd_sel_b))));
            check("u4.carry", {3'b000, c4}, 4'(mcarry[0]));
            check("u4.zero", {3'b000, z4}, 4'(mzero[0]));
            check("u3.dat_out_a", a3, 4'(exp_rd(1, int'(rd_sel_a))));
            check("u3.dat_out_b", b3, 4'(exp_rd(1, int'(rd_sel_b))));
            check("u3.carry", {3'b000, c3}, 4'(mcarry[1]));
            check("u3.zero", {3'b000, z3}, 4'(mzero[1]));
        end
    end

    // One clock edge: advance the model with the inputs the DUT sampled.
    task automatic tick();
        int r;
        int c;
        @(posedge clk_cpu);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int j = 0; j < 4; j++) mreg[k][j] = 0;
                mcarry[k] = 0;
                mzero[k]  = 0;
            end else if (write_ok(k)) begin
                r = result(k, c);
                mreg[k][int'(wr_sel)] = r;
                mcarry[k] = c;
                mzero[k]  = (r == 0) ? 1 : 0;
            end
        end
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [1:0] op, input logic [3:0] d);
        we = 1'b1; wr_sel = sel; wr_op = op; dat_in = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) mreg[k][j] = 0;
            mcarry[k] = 0;
            mzero[k]  = 0;
        end
        tick();
        tick();
        reset  = 1'b0;
        chk_en = 1'b1;

        // Preload, then reset during a LOAD reg1=7.
        wr(2'd0, 2'b00, 4'h5);
        wr(2'd1, 2'b00, 4'hA);
        wr(2'd2, 2'b00, 4'hF);
        wr(2'd3, 2'b00, 4'h3);
        rd_sel_a = 2'd1; rd_sel_b = 2'd2; #1;
        check("preload r1", a4, 4'hA);
        check("preload r2", b4, 4'hF);
        reset = 1'b1; we = 1'b1; wr_sel = 2'd1; wr_op = 2'b00; dat_in = 4'h7;
        tick();
        reset = 1'b0; we = 1'b0;
        rd_sel_b = 2'd3; #1;
        check("reset r1", a4, 4'h0);
        check("reset r3", b4, 4'h0);
        check("reset carry", {3'b000, c4}, 4'h0);
        check("reset zero", {3'b000, z4}, 4'h0);

        // LOAD and dual read.
        wr(2'd2, 2'b00, 4'h9);
        check("load9 zero", {3'b000, z4}, 4'h0);
        wr(2'd3, 2'b00, 4'h6);
        check("load6 carry", {3'b000, c4}, 4'h0);
        rd_sel_a = 2'd2; rd_sel_b = 2'd3; #1;
        check("dual a", a4, 4'h9);
        check("dual b", b4, 4'h6);
        check("u3 oor read", b3, 4'h0);

        // INC wrap and flag hold.
        rd_sel_a = 2'd1;
        wr(2'd1, 2'b00, 4'hE);
        wr(2'd1, 2'b01, 4'h0);
        check("inc F", a4, 4'hF);
        check("inc F carry", {3'b000, c4}, 4'h0);
        wr(2'd1, 2'b01, 4'h0);
        check("inc wrap", a4, 4'h0);
        check("inc wrap carry", {3'b000, c4}, 4'h1);
        check("inc wrap zero", {3'b000, z4}, 4'h1);
        wr_op = 2'b11;
        tick();
        check("hold carry", {3'b000, c4}, 4'h1);
        check("hold zero", {3'b000, z4}, 4'h1);

        // Out-of-range write on the 3-register instance.
        wr(2'd3, 2'b00, 4'h5);
        check("oor u3 carry", {3'b000, c3}, 4'h1);
        check("oor u3 zero", {3'b000, z3}, 4'h1);
        check("oor u3 read", b3, 4'h0);
        check("u4 r3 load", b4, 4'h5);

        // CLEAR then DEC borrow.
        rd_sel_a = 2'd0;
        wr(2'd0, 2'b11, 4'h0);
        check("clear zero", {3'b000, z4}, 4'h1);
        wr(2'd0, 2'b10, 4'h0);
        check("dec borrow", a4, 4'hF);
        check("dec borrow carry", {3'b000, c4}, 4'h1);
        wr(2'd0, 2'b10, 4'h0);
        check("dec E", a4, 4'hE);
        check("dec E carry", {3'b000, c4}, 4'h0);

        // Read during write of reg2 (holding 9).
        rd_sel_a = 2'd2;
        we = 1'b1; wr_sel = 2'd2; wr_op = 2'b00; dat_in = 4'h4;
        #2;
`ifdef CPU_REGBANK_BYPASS_EN
        check("rdw pre-edge", a4, 4'h4);
`else
        check("rdw pre-edge", a4, 4'h9);
`endif
        tick();
        we = 1'b0; #1;
        check("rdw post-edge", a4, 4'h4);

        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_register_bank.md
Name: cpu_register_bank

Overview:
- Parametrised multi-register bank for the FourBitCPU datapath. Generalises the single load-enable register into NREG registers of width W.
- Provides one write port with in-place arithmetic ops (load, increment, decrement, clear) and two independent combinational read ports.
- Produces registered carry/borrow and zero flags that the control unit consumes.
- Sits between the ALU result bus and the ALU operand muxes.

Parameters:
- W, 4, data width of each register.
- NREG, 4, number of registers; any value from 2 to 2**AW.
- AW, 2, register select width.

Ports:
- clk_cpu  in  1  CPU clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk_cpu.
- we  in  1  write enable.
- wr_sel  in  AW  destination register index.
- wr_op  in  2  write operation: 00 LOAD, 01 INC, 10 DEC, 11 CLEAR.
- dat_in  in  W  write data; used by LOAD only.
- rd_sel_a  in  AW  read port A index.
- rd_sel_b  in  AW  read port B index.
- dat_out_a  out  W  contents of register rd_sel_a.
- dat_out_b  out  W  contents of register rd_sel_b.
- carry  out  1  registered carry/borrow flag from the last accepted write.
- zero  out  1  registered flag, set when the last accepted write result was 0.

Behaviour:
- Reset (reset=1 at a clk_cpu edge):
  - All registers go to 0; carry goes to 0; zero goes to 0.
  - Reset has priority over we.
  - Reset asserted mid-sequence discards that cycle's write.
  - No asynchronous effect: outputs change only at the edge.
- Write accepted: we=1, reset=0 and wr_sel < NREG. The result R is stored in reg[wr_sel] at the edge:
  - LOAD: R = dat_in; carry <= 0.
  - INC: R = reg + 1, modulo 2**W; carry <= 1 only when the old value is all-ones (wraps to 0), else 0.
  - DEC: R = reg - 1, modulo 2**W; carry <= 1 only when the old value is 0 (wraps to all-ones, borrow), else 0.
  - CLEAR: R = 0; carry <= 0.
  - zero <= (R == 0) for every accepted write.
- Write not accepted (we=0, or wr_sel >= NREG): no register changes; carry and zero hold their previous values.
- Latency:
  - Write-to-read: 1 cycle. A register written at edge N is visible on the read ports after edge N.
  - Flags update at the same edge as the write.
- Read ports:
  - Purely combinational from stored state.
  - Both ports may select the same register, or the register being written.
  - Out-of-range index (>= NREG) returns 0.
- Read-during-write, same cycle, without the optional feature: the read port returns the old (pre-edge) value.
- Only one write per cycle. wr_op is ignored when we=0.
- All arithmetic is W bits wide; no overflow beyond carry.

Optional Feature:
- Macro: CPU_REGBANK_BYPASS_EN.
- Defined:
  - When we=1, reset=0, wr_sel valid and rd_sel_x == wr_sel, dat_out_x combinationally shows the result R being written this cycle, including INC/DEC/CLEAR results.
  - Write-to-read latency becomes 0 cycles.
  - No bypass while reset=1; reads then show stored values.
- Undefined: no bypass path; same-cycle reads return the pre-edge value, as described in Behaviour.

Test Plan:
- Reset behaviour: preload reg0..3 = 5,A,F,3, assert reset one cycle with we=1 LOAD reg1=7 -> all regs read 0, carry=0, zero=0; reg1 is not 7.
- LOAD and dual read: LOAD reg2=0x9, LOAD reg3=0x6; then rd_sel_a=2, rd_sel_b=3 -> dat_out_a=9, dat_out_b=6; zero=0, carry=0 after each write.
- INC wrap: LOAD reg1=0xE, INC reg1, INC reg1 -> reg1 reads F (carry=0, zero=0), then 0 (carry=1, zero=1); we=0 next cycle -> flags hold 1/1.
- DEC borrow and CLEAR: CLEAR reg0 -> zero=1, carry=0; DEC reg0 -> reg0=F, carry=1, zero=0; DEC reg0 -> E, carry=0.
- Read-during-write: rd_sel_a=2 (holding 9), LOAD reg2=4 in the same cycle -> dat_out_a=9 before the edge without CPU_REGBANK_BYPASS_EN, 4 with it; dat_out_a=4 after the edge in both builds.
- Out-of-range (NREG=3): we=1 LOAD wr_sel=3 dat_in=5 -> no register changes, flags unchanged; rd_sel_b=3 -> dat_out_b=0.
